// File: rtl/arith_pkg.sv
// Shared types and constants for the handshaked arithmetic responder.
package arith_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Divide-by-zero result is all ones; users slice down to their own width.
  localparam int unsigned MAX_WIDTH = 256;
  localparam logic [MAX_WIDTH-1:0] DIV_ZERO_RESULT = '1;

endpackage

// File: rtl/arith_div_iter.sv
// Unsigned restoring divider: one quotient bit per enabled step, WIDTH steps total.
module arith_div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             step,
  output logic             done_c,
  output logic [WIDTH-1:0] quotient_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quot_d;

  // Trial subtraction; quot_q doubles as the dividend shift register.
  always_comb begin
    partial = {rem_q, quot_q[WIDTH-1]};
    diff    = partial - {1'b0, dvsr_q};
    rem_d   = diff[WIDTH-1:0];
    quot_d  = {quot_q[WIDTH-2:0], 1'b1};
    if (diff[WIDTH]) begin
      rem_d  = partial[WIDTH-1:0];
      quot_d = {quot_q[WIDTH-2:0], 1'b0};
    end
    done_c     = step && (cnt_q == CNT_W'(WIDTH - 1));
    quotient_c = quot_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      rem_q  <= '0;
      quot_q <= dividend;
      dvsr_q <= divisor;
      cnt_q  <= '0;
    end else if (step) begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/arith_seq_alu.sv
// Handshaked signed add/sub/mul/div responder; division runs one bit per cycle.
module arith_seq_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  import arith_pkg::*;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_d;
  logic             dbz_d;
  logic             neg_q, neg_d;
  logic             req_ready_d;
  logic             resp_valid_d;

  op_e              op;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_start;
  logic             div_step;
  logic             div_done_c;
  logic [WIDTH-1:0] div_quot_c;

  arith_div_iter #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .start      (div_start),
    .dividend   (a_mag),
    .divisor    (b_mag),
    .step       (div_step),
    .done_c     (div_done_c),
    .quotient_c (div_quot_c)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d   = state_q;
    r_d       = r;
    dbz_d     = div_by_zero;
    neg_d     = neg_q;
    div_start = 1'b0;
    div_step  = 1'b0;
    op        = op_e'(sel);
    a_mag     = a[WIDTH-1] ? -a : a;
    b_mag     = b[WIDTH-1] ? -b : b;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          dbz_d   = 1'b0;
          state_d = ST_RESP;
          case (op)
            OP_ADD: r_d = a + b;
            OP_SUB: r_d = a - b;
            OP_MUL: r_d = a * b;
            OP_DIV: begin
              if (b == '0) begin
                r_d   = DIV_ZERO_RESULT[WIDTH-1:0];
                dbz_d = 1'b1;
              end else begin
                div_start = 1'b1;
                neg_d     = a[WIDTH-1] ^ b[WIDTH-1];
                state_d   = ST_DIV;
              end
            end
            default: r_d = r;
          endcase
        end
      end
      ST_DIV: begin
        div_step = 1'b1;
        if (div_done_c) begin
          r_d     = neg_q ? -div_quot_c : div_quot_c;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      r           <= '0;
      div_by_zero <= 1'b0;
      neg_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready   <= req_ready_d;
      resp_valid  <= resp_valid_d;
      r           <= r_d;
      div_by_zero <= dbz_d;
      neg_q       <= neg_d;
    end
  end

endmodule
